// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage and the register file it feeds from.
// The width macros live here so every file compiled after the package sees them.
`ifndef SIZE
`define SIZE 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif

package operand_fetch_pkg;
  localparam int OF_WIDTH = `SIZE;
  localparam int OF_AW    = `REG_AW;
  localparam int OF_LANES = 2;

  typedef logic [OF_AW-1:0]    reg_idx_t;
  typedef logic [OF_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and ALU-side valid/ready channels of the operand fetch stage.
interface operand_fetch_if #(
  parameter int WIDTH = operand_fetch_pkg::OF_WIDTH,
  parameter int AW    = operand_fetch_pkg::OF_AW
);
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [AW-1:0]    in_rd;
  logic             in_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [AW-1:0]    out_rd;
  logic             out_we;

  // master: decode driving in and ALU consuming out; slave: the stage itself
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_we, out_ready,
    input  in_ready, out_valid, op_a, op_b, out_rd, out_we
  );
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_we, out_ready,
    output in_ready, out_valid, op_a, op_b, out_rd, out_we
  );
endinterface

// File: rtl/operand_bypass.sv
// One operand lane: substitutes the writeback value when writeback targets this source index.
module operand_bypass #(
  parameter int WIDTH = operand_fetch_pkg::OF_WIDTH,
  parameter int AW    = operand_fetch_pkg::OF_AW
) (
  input  logic             i_wb_write,
  input  logic [AW-1:0]    i_wb_reg,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic [AW-1:0]    i_rs,
  input  logic [WIDTH-1:0] i_rf_data,
  output logic [WIDTH-1:0] o_data
);
  assign o_data = (i_wb_write && (i_wb_reg == i_rs)) ? i_wb_data : i_rf_data;
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register file reads, bypasses writeback, and registers
// operands for the ALU behind a valid/ready handshake with flush and stall-time refresh.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = `SIZE,
  parameter int AW    = `REG_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  operand_fetch_if.slave   bus,
  output logic [AW-1:0]    readReg1,
  output logic [AW-1:0]    readReg2,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic             wb_write,
  input  logic [AW-1:0]    wb_reg,
  input  logic [WIDTH-1:0] wb_data
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_op [OF_LANES];
  logic [AW-1:0]    r_held_rs [OF_LANES];
  logic [AW-1:0]    r_out_rd;
  logic             r_out_we;

  logic [AW-1:0]    w_in_rs [OF_LANES];
  logic [WIDTH-1:0] w_rf_data [OF_LANES];
  logic [WIDTH-1:0] w_fetch_next [OF_LANES];
  logic [WIDTH-1:0] w_hold_next [OF_LANES];
  logic             w_in_ready;
  logic             w_accept;
  logic             w_transfer;

  assign w_in_rs[0]   = bus.in_rs1;
  assign w_in_rs[1]   = bus.in_rs2;
  assign w_rf_data[0] = readData1;
  assign w_rf_data[1] = readData2;

  assign readReg1 = bus.in_rs1;
  assign readReg2 = bus.in_rs2;

  // Each lane bypasses both the incoming fetch and the held operand during a stall.
  for (genvar gi = 0; gi < OF_LANES; gi++) begin : g_lane
    operand_bypass #(.WIDTH(WIDTH), .AW(AW)) u_fetch_bypass (
      .i_wb_write (wb_write),
      .i_wb_reg   (wb_reg),
      .i_wb_data  (wb_data),
      .i_rs       (w_in_rs[gi]),
      .i_rf_data  (w_rf_data[gi]),
      .o_data     (w_fetch_next[gi])
    );
    operand_bypass #(.WIDTH(WIDTH), .AW(AW)) u_hold_bypass (
      .i_wb_write (wb_write),
      .i_wb_reg   (wb_reg),
      .i_wb_data  (wb_data),
      .i_rs       (r_held_rs[gi]),
      .i_rf_data  (r_op[gi]),
      .o_data     (w_hold_next[gi])
    );
  end

  assign w_in_ready = !reset && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !flush;
  assign w_transfer = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_we    <= 1'b0;
      for (int i = 0; i < OF_LANES; i++) begin
        r_op[i]      <= '0;
        r_held_rs[i] <= '0;
      end
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_rd    <= bus.in_rd;
      r_out_we    <= bus.in_we;
      for (int i = 0; i < OF_LANES; i++) begin
        r_op[i]      <= w_fetch_next[i];
        r_held_rs[i] <= w_in_rs[i];
      end
    end else if (w_transfer) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid) begin
      for (int i = 0; i < OF_LANES; i++) begin
        r_op[i] <= w_hold_next[i];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op_a      = r_op[0];
  assign bus.op_b      = r_op[1];
  assign bus.out_rd    = r_out_rd;
  assign bus.out_we    = r_out_we;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: handshake, bypass, stall refresh, flush and reset.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      flush;
  reg_idx_t  readReg1, readReg2;
  reg_data_t readData1, readData2;
  logic      wb_write;
  reg_idx_t  wb_reg;
  reg_data_t wb_data;

  int n_vec = 0;
  int n_err = 0;

  operand_fetch_if #(.WIDTH(OF_WIDTH), .AW(OF_AW)) bus ();

  operand_fetch #(.WIDTH(OF_WIDTH), .AW(OF_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .wb_write  (wb_write),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic issue(input reg_idx_t rs1, input reg_idx_t rs2, input reg_idx_t rd,
                       input logic we, input reg_data_t d1, input reg_data_t d2);
    bus.in_valid = 1'b1;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_rd = rd;
    bus.in_we = we;
    readData1 = d1;
    readData2 = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wb_write = 1'b0; wb_reg = '0; wb_data = '0;
    readData1 = '0; readData2 = '0;
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_we = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset op_a", bus.op_a, 0);
    chk("reset op_b", bus.op_b, 0);
    chk("reset out_rd", 32'(bus.out_rd), 0);
    chk("reset out_we", 32'(bus.out_we), 0);
    chk("reset in_ready forced low", 32'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic test_basic();
    issue(5'd10, 5'd15, 5'd3, 1'b1, 32'd12345, 32'd54321);
    #1;
    chk("basic readReg1", 32'(readReg1), 10);
    chk("basic readReg2", 32'(readReg2), 15);
    step();
    bus.in_valid = 1'b0;
    chk("basic out_valid", 32'(bus.out_valid), 1);
    chk("basic op_a", bus.op_a, 12345);
    chk("basic op_b", bus.op_b, 54321);
    chk("basic out_rd", 32'(bus.out_rd), 3);
    chk("basic out_we", 32'(bus.out_we), 1);
    step();
    chk("basic drain out_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic test_bypass();
    issue(5'd10, 5'd15, 5'd4, 1'b0, 32'd111, 32'd54321);
    wb_write = 1'b1; wb_reg = 5'd15; wb_data = 32'd2332;
    step();
    chk("bypass op_b hit", bus.op_b, 2332);
    chk("bypass op_a miss", bus.op_a, 111);
    wb_write = 1'b0;
    step();
    chk("nobypass op_b", bus.op_b, 54321);
    issue(5'd7, 5'd7, 5'd8, 1'b1, 32'd1, 32'd2);
    wb_write = 1'b1; wb_reg = 5'd7; wb_data = 32'd99;
    step();
    chk("dual bypass op_a", bus.op_a, 99);
    chk("dual bypass op_b", bus.op_b, 99);
    wb_write = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("bypass drain out_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic test_stall_refresh();
    issue(5'd10, 5'd20, 5'd11, 1'b1, 32'd12345, 32'd500);
    bus.out_ready = 1'b0;
    step();
    issue(5'd5, 5'd6, 5'd12, 1'b0, 32'd1, 32'd2);
    wb_write = 1'b1; wb_reg = 5'd10; wb_data = 32'd777;
    #1;
    chk("stall in_ready", 32'(bus.in_ready), 0);
    step();
    chk("refresh op_a", bus.op_a, 777);
    chk("refresh op_b untouched", bus.op_b, 500);
    chk("stall out_valid", 32'(bus.out_valid), 1);
    chk("stall out_rd held", 32'(bus.out_rd), 11);
    wb_reg = 5'd20; wb_data = 32'd888;
    step();
    chk("refresh op_b", bus.op_b, 888);
    chk("refresh op_a kept", bus.op_a, 777);
    wb_write = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("stall release out_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 5'(i + 8), 5'(i), 1'b1, 32'(i * 100), 32'(i * 1000));
      #1;
      chk("b2b in_ready", 32'(bus.in_ready), 1);
      step();
      chk("b2b out_valid", 32'(bus.out_valid), 1);
      chk("b2b out_rd", 32'(bus.out_rd), 32'(i));
      chk("b2b op_a", bus.op_a, 32'(i * 100));
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b drain out_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic test_flush();
    issue(5'd1, 5'd2, 5'd9, 1'b1, 32'd5, 32'd6);
    bus.out_ready = 1'b0;
    step();
    chk("flush setup out_valid", 32'(bus.out_valid), 1);
    issue(5'd3, 5'd4, 5'd6, 1'b1, 32'd7, 32'd8);
    bus.out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush out_valid", 32'(bus.out_valid), 0);
    step();
    chk("flush no late present", 32'(bus.out_valid), 0);
  endtask

  task automatic test_reset_mid_stall();
    issue(5'd10, 5'd11, 5'd13, 1'b1, 32'd4242, 32'd2424);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("midstall out_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midstall reset out_valid", 32'(bus.out_valid), 0);
    chk("midstall reset op_a", bus.op_a, 0);
    chk("midstall reset op_b", bus.op_b, 0);
    chk("midstall reset in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall_refresh();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
